// File: rtl/data_mem_pkg.sv
// ------------------------------------------------------------------
// data_mem_pkg : shared size encodings, IO map and load/lane helpers. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  localparam logic [31:0] IO_IN_ADDR   = 32'd0;
  localparam logic [31:0] IO_OUT_ADDR  = 32'd4;
  localparam logic [31:0] IO_FLAG_ADDR = 32'd8;
  localparam logic [31:0] HEAP_BASE    = 32'd12;

  // Bit L of the mask selects the byte at word offset L (offset 0 = bits 31:24).
  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (sz)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {2'd3 - off, 3'b000});
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_mmio_if.sv
// ------------------------------------------------------------------
// data_mem_mmio_if : load/store request bus with registered response. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface data_mem_mmio_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;

  modport master (output req, we, size, uns, addr, wdata, input rdata, rvalid, err);
  modport slave  (input req, we, size, uns, addr, wdata, output rdata, rvalid, err);
endinterface

`default_nettype wire

// File: rtl/data_mem_mmio_io_sync.sv
// ------------------------------------------------------------------
// io_sync : two-flop synchronizer for asynchronous input ports. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module io_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q;

endmodule

`default_nettype wire

// File: rtl/data_mem_mmio.sv
// ------------------------------------------------------------------
// data_mem_mmio : big-endian byte-addressed data memory with IO words. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int N_IN        = 1,
  parameter int N_OUT       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_mmio_if.slave       bus,
  input  logic [8*N_IN-1:0]    i_in,
  output logic [8*N_OUT-1:0]   o_out,
  output logic                 irq
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam int          HEAP_WORDS = DEPTH_WORDS - 3;
  localparam int          HW         = (HEAP_WORDS > 1) ? $clog2(HEAP_WORDS) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  logic [8*N_IN-1:0]  in_sync;
  logic [8*N_IN-1:0]  prev_q, prev_d;
  logic [8*N_OUT-1:0] out_q, out_d;
  logic [N_IN-1:0]    flag_q, flag_d;
  logic [1:0]         settle_q, settle_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;

  logic          acc, fault, st_ok, is_heap;
  logic [1:0]    off;
  logic [AW-1:0] widx;
  logic [HW-1:0] hidx;
  logic [3:0]    mask, heap_we;
  logic [31:0]   wword, rword;
  logic [7:0]    lane_rd [4];

  io_sync #(.WIDTH(8*N_IN)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (i_in),
    .dout  (in_sync)
  );

  // Address decode; stores are lane-replicated so each lane picks its own byte.
  always_comb begin
    acc     = bus.req & ~reset;
    off     = bus.addr[1:0];
    widx    = bus.addr[AW+1:2];
    hidx    = HW'(widx - AW'(HEAP_BASE >> 2));
    mask    = lane_mask(bus.size, off);
    fault   = (bus.size == SZ_ILLEGAL)
            | ((bus.size == SZ_HALF) & off[0])
            | ((bus.size == SZ_WORD) & (off != 2'd0))
            | (bus.addr >= ADDR_LIMIT);
    st_ok   = acc & bus.we & ~fault;
    is_heap = widx >= AW'(HEAP_BASE >> 2);
    heap_we = (st_ok && is_heap) ? mask : 4'b0000;
    case (bus.size)
      SZ_BYTE: wword = {4{bus.wdata[7:0]}};
      SZ_HALF: wword = {2{bus.wdata[15:0]}};
      default: wword = bus.wdata;
    endcase
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [HEAP_WORDS];
    always_ff @(posedge clk) begin
      if (heap_we[l]) mem[hidx] <= wword[31-8*l -: 8];
    end
    assign lane_rd[l] = mem[hidx];
  end

  always_comb begin
    rword = '0;
    if (widx == AW'(IO_IN_ADDR >> 2)) begin
      rword = 32'(in_sync);
    end else if (widx == AW'(IO_OUT_ADDR >> 2)) begin
      rword = 32'(out_q);
    end else if (widx == AW'(IO_FLAG_ADDR >> 2)) begin
      for (int k = 0; k < N_IN; k++) rword[9*k] = flag_q[k];
    end else begin
      rword = {lane_rd[0], lane_rd[1], lane_rd[2], lane_rd[3]};
    end
  end

  always_comb begin
    prev_d   = in_sync;
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    out_d    = out_q;
    flag_d   = flag_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = acc & fault;
    if (acc && !bus.we) begin
      rvalid_d = 1'b1;
      rdata_d  = fault ? 32'd0 : load_extract(rword, bus.size, off, bus.uns);
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (st_ok && widx == AW'(IO_OUT_ADDR >> 2) && mask[3-k]) out_d[8*k +: 8] = wword[8*k +: 8];
    end
    // Compare is held off until prev_q has caught up with the refilled synchronizer.
    for (int k = 0; k < N_IN; k++) begin
      if (settle_q == 2'd3 && in_sync[8*k +: 8] != prev_q[8*k +: 8]) begin
        flag_d[k] = 1'b1;
      end else if (st_ok && widx == AW'(IO_FLAG_ADDR >> 2) && mask[3-k] && wword[9*k]) begin
        flag_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= '0;
      out_q    <= '0;
      flag_q   <= '0;
      settle_q <= 2'd0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      out_q    <= out_d;
      flag_q   <= flag_d;
      settle_q <= settle_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Gating by reset kills a response already in flight when reset arrives.
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q & ~reset;
  assign bus.err    = err_q & ~reset;
  assign o_out      = out_q;
  assign irq        = |flag_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
// ------------------------------------------------------------------
// tb_data_mem_mmio : self-checking bench for data_mem_mmio. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_data_mem_mmio;
  import data_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_in;
  logic [23:0] o_out;
  logic        irq;

  data_mem_mmio_if bus ();

  data_mem_mmio #(.DEPTH_WORDS(32), .N_IN(1), .N_OUT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .i_in  (i_in),
    .o_out (o_out),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = w; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // Drive one request; the expected response is queued and compared the cycle after.
  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                        input logic ee);
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = wd;
    e.rvalid = ~w; e.rdata = er; e.err = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    got.rvalid = bus.rvalid; got.rdata = bus.rdata; got.err = bus.err;
    e = sb.pop_front();
    check({tag, " rvalid"}, 32'(got.rvalid), 32'(e.rvalid));
    check({tag, " err"}, 32'(got.err), 32'(e.err));
    if (e.rvalid) check({tag, " rdata"}, got.rdata, e.rdata);
  endtask

  initial begin
    reset = 1'b1; i_in = 8'h00;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = SZ_WORD; bus.uns = 1'b0;
    bus.addr = '0; bus.wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset rvalid", 32'(bus.rvalid), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    check("reset rdata", bus.rdata, 32'd0);
    check("reset o_out", 32'(o_out), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // we, size, uns, addr, wdata, expected rdata, expected err
    add(1, SZ_WORD, 0, 32'd12,  32'hDEADBEEF, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'd12,  32'h0,        32'hDEADBEEF, 0);
    add(0, SZ_BYTE, 0, 32'd13,  32'h0,        32'hFFFFFFAD, 0);
    add(0, SZ_BYTE, 1, 32'd13,  32'h0,        32'h000000AD, 0);
    add(0, SZ_HALF, 0, 32'd14,  32'h0,        32'hFFFFBEEF, 0);
    add(0, SZ_HALF, 1, 32'd12,  32'h0,        32'h0000DEAD, 0);
    add(0, SZ_BYTE, 0, 32'd15,  32'h0,        32'hFFFFFFEF, 0);
    add(1, SZ_BYTE, 0, 32'd15,  32'hAAAAAA5C, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'd12,  32'h0,        32'hDEADBE5C, 0);
    add(1, SZ_HALF, 0, 32'd6,   32'hFFFF1234, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'd4,   32'h0,        32'h00001234, 0);
    add(1, SZ_BYTE, 0, 32'd4,   32'h00000077, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'd4,   32'h0,        32'h00001234, 0);
    add(1, SZ_WORD, 0, 32'd0,   32'h11223344, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'd0,   32'h0,        32'h00000000, 0);
    add(0, SZ_WORD, 0, 32'd8,   32'h0,        32'h00000000, 0);
    add(0, SZ_WORD, 0, 32'd14,  32'h0,        32'h0,        1);
    add(1, SZ_HALF, 0, 32'd13,  32'h00000000, 32'h0,        1);
    add(1, SZ_WORD, 0, 32'd14,  32'h00000000, 32'h0,        1);
    add(0, SZ_WORD, 0, 32'd128, 32'h0,        32'h0,        1);
    add(0, SZ_BYTE, 1, 32'd128, 32'h0,        32'h0,        1);
    add(0, 2'd3,    0, 32'd12,  32'h0,        32'h0,        1);
    add(1, 2'd3,    0, 32'd12,  32'h00000000, 32'h0,        1);
    add(1, SZ_WORD, 0, 32'd128, 32'h12345678, 32'h0,        1);
    add(0, SZ_WORD, 0, 32'd12,  32'h0,        32'hDEADBE5C, 0);
    add(1, SZ_WORD, 0, 32'd124, 32'hCAFEF00D, 32'h0,        0);
    add(0, SZ_WORD, 0, 32'd124, 32'h0,        32'hCAFEF00D, 0);
    add(0, SZ_BYTE, 1, 32'd127, 32'h0,        32'h0000000D, 0);
    add(0, SZ_HALF, 1, 32'd126, 32'h0,        32'h0000F00D, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      access($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end
    check("o_out after half store", 32'(o_out), 32'h00001234);

    @(posedge clk);
    #1;
    check("idle rvalid", 32'(bus.rvalid), 32'd0);
    check("idle rdata hold", bus.rdata, 32'h0000F00D);
    check("idle err", 32'(bus.err), 32'd0);

    // Input change propagates through the synchronizer and raises a flag.
    i_in = 8'h5A;
    access("in0 c1", 0, SZ_WORD, 0, 32'd0, 32'h0, 32'h00000000, 0);
    access("in0 c2", 0, SZ_WORD, 0, 32'd0, 32'h0, 32'h00000000, 0);
    check("irq before flag", 32'(irq), 32'd0);
    access("in0 c3", 0, SZ_WORD, 0, 32'd0, 32'h0, 32'h0000005A, 0);
    check("irq set", 32'(irq), 32'd1);
    access("flags read", 0, SZ_WORD, 0, 32'd8, 32'h0, 32'h00000001, 0);
    access("flag w1c", 1, SZ_BYTE, 0, 32'd11, 32'h00000001, 32'h0, 0);
    check("irq cleared", 32'(irq), 32'd0);

    // Clear lands on the same edge as a new change: set wins.
    i_in = 8'hA5;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("irq pre-collide", 32'(irq), 32'd0);
    access("collide w1c", 1, SZ_BYTE, 0, 32'd11, 32'h00000001, 32'h0, 0);
    check("irq after collide", 32'(irq), 32'd1);
    access("collide flags", 0, SZ_WORD, 0, 32'd8, 32'h0, 32'h00000001, 0);
    access("flag w1c 2", 1, SZ_BYTE, 0, 32'd11, 32'h00000001, 32'h0, 0);
    check("irq cleared 2", 32'(irq), 32'd0);

    // Reset lands while a load response is pending.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = SZ_WORD; bus.uns = 1'b0; bus.addr = 32'd12;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst kill rvalid", 32'(bus.rvalid), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst rvalid", 32'(bus.rvalid), 32'd0);
    end
    check("rst o_out", 32'(o_out), 32'd0);
    check("rst rdata", bus.rdata, 32'd0);
    check("rst err", 32'(bus.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post-rst rvalid", 32'(bus.rvalid), 32'd0);
    check("post-rst irq", 32'(irq), 32'd0);
    access("heap kept", 0, SZ_BYTE, 1, 32'd12, 32'h0, 32'h000000DE, 0);
    access("in0 post-rst", 0, SZ_WORD, 0, 32'd0, 32'h0, 32'h000000A5, 0);
    access("flags post-rst", 0, SZ_WORD, 0, 32'd8, 32'h0, 32'h00000000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 32: total 32-bit words in the map, including 3 IO words; legal range 4..1024.
REQ-002 SHALL have parameter N_IN, default 1: number of 8-bit input ports; legal range 1..4.
REQ-003 SHALL have parameter N_OUT, default 3: number of 8-bit output ports; legal range 1..4.
REQ-004 SHALL provide the following ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  access request, one per cycle.
- we  in  1  1 = store, 0 = load.
- size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- uns  in  1  load zero-extends when 1, sign-extends when 0.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- rdata  out  32  load data, right-justified.
- rvalid  out  1  load data valid.
- err  out  1  access fault pulse.
- i_in  in  8*N_IN  asynchronous inputs.
- o_out  out  8*N_OUT  output ports.
- irq  out  1  any change flag set.

Function
REQ-005 SHALL use a byte-addressable, big-endian map: the byte at addr A holds bits 31:24 of word A/4.
REQ-006 SHALL map word 0 (bytes 0-3) to synchronized inputs: i_in byte k reads at address 3-k; bytes with no port read 0; writes are ignored without err.
REQ-007 SHALL map word 1 (bytes 4-7) to read/write output registers: o_out byte k is driven by address 7-k; bytes with no port read 0 and ignore writes.
REQ-008 SHALL map word 2 (bytes 8-11) to sticky change flags: bit k of byte 11-k sets when synchronized input byte k differs from its previous-cycle value; writing 1 to a bit clears it.
REQ-009 SHALL resolve a flag set and a W1C clear in the same cycle as set.
REQ-010 SHALL map bytes 12 to 4*DEPTH_WORDS-1 to heap RAM.
REQ-011 SHALL pass i_in through a 2-flop synchronizer; word-0 reads and change detection use the second stage.
REQ-012 SHALL commit a store at the rising edge on which req=1 and we=1.
REQ-013 SHALL write only the bytes selected by size: a byte store writes wdata[7:0]; a half store writes wdata[15:0], MSB at A.
REQ-014 SHALL register load data: rdata and rvalid are valid exactly 1 cycle after req=1 with we=0.
REQ-015 SHALL have rvalid low in all other cycles; rdata holds its last value while rvalid is low.
REQ-016 SHALL return the new data for a load issued the cycle after a store to the same address.
REQ-017 SHALL fault on: a misaligned access (half with addr[0]=1, word with addr[1:0]!=0); addr >= 4*DEPTH_WORDS; or size=3.
REQ-018 SHALL, on a fault, pulse err 1 cycle after req, suppress any write, and for a load assert rvalid with rdata=0.
REQ-019 SHALL drive irq combinationally as the OR of all change-flag bits.

Reset
REQ-020 SHALL, while reset=1, clear: the synchronizer, the previous-input register, the output registers, the change flags, rdata, rvalid, err.
REQ-021 SHALL leave heap RAM contents unchanged on reset.
REQ-022 SHALL ignore req while reset=1.
REQ-023 SHALL discard a load in flight when reset asserts mid-operation: no rvalid afterwards.
REQ-024 SHALL suppress the change-flag compare during the first 2 cycles after reset deasserts, so reset release raises no spurious flags.

Structure
REQ-025 SHALL place the size encodings, the IO word addresses (0, 4, 8) and the heap base (12) in a shared package data_mem_pkg.
REQ-026 SHALL implement the synchronizer as one sub-module io_sync, parametrised by width.
REQ-027 SHALL implement the heap as an inferred byte-lane RAM, 4 lanes of DEPTH_WORDS-3 entries.

Verification
REQ-028 SHALL cover: store word 0xDEADBEEF @12, then load word @12, then load byte uns=0 @13 -> rdata=0xDEADBEEF then 0xFFFFFFAD, each with rvalid 1 cycle later.
REQ-029 SHALL cover: store half 0x1234 @6 with N_OUT=3 -> o_out=0x001234; load word @4 -> 0x00001234.
REQ-030 SHALL cover: i_in 0x00 -> 0x5A -> word 0 reads 0x0000005A from the 3rd cycle; bit 0 of byte 11 set; irq=1; store 0x01 @11 -> irq=0.
REQ-031 SHALL cover: load word @14, store half @13, access @128 with DEPTH_WORDS=32, size=3 -> err pulses each time, no memory change, load rdata=0.
REQ-032 SHALL cover: flag clear coinciding with a new input change -> flag remains 1.
REQ-033 SHALL cover: reset asserted the cycle after a load req -> rvalid stays 0, o_out=0, heap byte @12 retains 0xDE.
